dmux8way_dispatch: RTL and testbench



---
 rtl/dmux8way_dispatch_pkg.sv | 29 ++
 rtl/dmux8way_dispatch_dmux8way.sv | 56 +++++
 rtl/dmux8way_dispatch.sv | 156 +++++++++++++++
 tb/tb_dmux8way_dispatch.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dmux8way_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// dmux_pkg
// Shared definitions for the flow-controlled 1-to-8 demultiplexer front end.
//   - state_t   : dispatcher FSM states (IDLE waits for a word, HOLD presents it)
//   - NCH/SELW  : number of output channels and width of a channel select
//   - MODE_*    : encoding of the per-word routing mode input
//   - onehot()  : channel select to one-hot valid vector
// -----------------------------------------------------------------------------
package dmux_pkg;

    localparam int NCH  = 8;
    localparam int SELW = 3;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [NCH-1:0] onehot(input logic [SELW-1:0] sel);
        logic [NCH-1:0] vec;
        vec      = '0;
        vec[sel] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/dmux8way_dispatch_dmux8way.sv
// -----------------------------------------------------------------------------
// dmux8way
// Plain combinational 1-to-8 demultiplexer. The selected output carries the
// input word, every other output reads zero. When en is low all outputs are
// zero, which lets the dispatcher blank the channels outside of HOLD.
// Ports:
//   in_data   : word to route
//   sel       : destination channel
//   en        : output enable (all outputs forced to 0 when low)
//   out0..7   : channel outputs
// -----------------------------------------------------------------------------
module dmux8way
    import dmux_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in_data,
    input  logic [SELW-1:0]  sel,
    input  logic             en,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [WIDTH-1:0] out7
);

    // Every output starts at zero so that only the selected channel ever
    // carries data; consumers rely on unselected channels reading 0.
    always_comb begin
        out0 = '0;
        out1 = '0;
        out2 = '0;
        out3 = '0;
        out4 = '0;
        out5 = '0;
        out6 = '0;
        out7 = '0;
        if (en) begin
            case (sel)
                3'd0: out0 = in_data;
                3'd1: out1 = in_data;
                3'd2: out2 = in_data;
                3'd3: out3 = in_data;
                3'd4: out4 = in_data;
                3'd5: out5 = in_data;
                3'd6: out6 = in_data;
                3'd7: out7 = in_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dmux8way_dispatch.sv
// -----------------------------------------------------------------------------
// dmux8way_dispatch
// Sequenced, flow-controlled front end for the 16-bit 1-to-8 demultiplexer.
// A single-entry buffer accepts words over valid/ready and presents each one
// on exactly one of eight channels. The channel comes either from in_dest
// (addressed mode) or from a rotating pointer (round-robin mode). A word that
// its consumer does not take within TIMEOUT cycles is dropped so one dead
// consumer cannot block the others.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   in_valid/in_ready   : input handshake
//   in_data, in_dest    : input word and its addressed-mode destination
//   mode                : 0 = addressed, 1 = round-robin (sampled at accept)
//   out0..out7          : channel data, zero on non-selected channels
//   out_valid           : one-hot channel valid
//   out_ready           : per-channel consumer ready
//   drop                : one-cycle pulse after a word is discarded on timeout
//   rr_ptr              : current round-robin pointer
// -----------------------------------------------------------------------------
module dmux8way_dispatch
    import dmux_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SELW-1:0]  in_dest,
    input  logic             mode,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [WIDTH-1:0] out7,
    output logic [NCH-1:0]   out_valid,
    input  logic [NCH-1:0]   out_ready,
    output logic             drop,
    output logic [SELW-1:0]  rr_ptr
);

    // The stall counter runs 0..TIMEOUT-1 while a word waits, so the last
    // permitted stall cycle is the one where it equals TIMEOUT-1.
    localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT - 1);

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] data_q,    data_d;
    logic [SELW-1:0]  sel_q,     sel_d;
    logic             rr_mode_q, rr_mode_d;
    logic [7:0]       cnt_q,     cnt_d;
    logic [SELW-1:0]  rr_ptr_q,  rr_ptr_d;
    logic             drop_q,    drop_d;

    logic holding;
    logic sel_ready;
    logic complete;
    logic timeout_hit;
    logic release_word;
    logic accept;

    // Handshake decode. The buffer frees up in the same cycle that the held
    // word leaves (completion or timeout), which is what allows one word per
    // cycle when the consumer keeps up. Ready bits of other channels are
    // deliberately not looked at.
    always_comb begin
        holding      = (state_q == HOLD);
        sel_ready    = out_ready[sel_q];
        complete     = holding && sel_ready;
        timeout_hit  = holding && !sel_ready && (cnt_q == STALL_LIMIT);
        release_word = complete || timeout_hit;
        in_ready     = !reset && (!holding || sel_ready || timeout_hit);
        accept       = in_valid && in_ready;
    end

    // Next-state logic for the buffer, pointer and stall counter. The pointer
    // is advanced before the incoming word picks its channel so that a word
    // captured on the same edge as a round-robin completion already sees the
    // next channel; this makes back-to-back round-robin words walk 0,1,2,...
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        sel_d     = sel_q;
        rr_mode_d = rr_mode_q;
        cnt_d     = cnt_q;
        rr_ptr_d  = rr_ptr_q;
        drop_d    = timeout_hit;

        if (release_word && rr_mode_q) begin
            rr_ptr_d = rr_ptr_q + 3'd1;
        end

        if (accept) begin
            state_d   = HOLD;
            data_d    = in_data;
            sel_d     = (mode == MODE_RR) ? rr_ptr_d : in_dest;
            rr_mode_d = mode;
            cnt_d     = '0;
        end else if (release_word) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (holding) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // State registers. Reset throws away any held word without a drop pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
            sel_q     <= '0;
            rr_mode_q <= 1'b0;
            cnt_q     <= '0;
            rr_ptr_q  <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            sel_q     <= sel_d;
            rr_mode_q <= rr_mode_d;
            cnt_q     <= cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            drop_q    <= drop_d;
        end
    end

    // Channel outputs come straight from the held registers, blanked outside
    // of HOLD so an idle dispatcher presents all-zero channels.
    always_comb begin
        out_valid = holding ? onehot(sel_q) : '0;
        drop      = drop_q;
        rr_ptr    = rr_ptr_q;
    end

    dmux8way #(
        .WIDTH (WIDTH)
    ) u_dmux (
        .in_data (data_q),
        .sel     (sel_q),
        .en      (holding),
        .out0    (out0),
        .out1    (out1),
        .out2    (out2),
        .out3    (out3),
        .out4    (out4),
        .out5    (out5),
        .out6    (out6),
        .out7    (out7)
    );

endmodule

// File: tb/tb_dmux8way_dispatch.sv
// -----------------------------------------------------------------------------
// tb_dmux8way_dispatch
// Self-checking bench for dmux8way_dispatch. A transaction-level reference
// model (held word, destination, remaining patience, pointer) predicts
// in_ready before each edge and every output after it. Directed scenarios
// come first, followed by a randomized run with alternating live/dead phases.
// -----------------------------------------------------------------------------
module tb_dmux8way_dispatch;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       in_dest;
    logic             mode;
    logic [WIDTH-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [7:0]       out_valid;
    logic [7:0]       out_ready;
    logic             drop;
    logic [2:0]       rr_ptr;

    int checks = 0;
    int errors = 0;

    // Reference model: is a word held, what it is, where it goes, whether it
    // was a round-robin word, and how many more stall cycles it may survive.
    bit         m_busy = 1'b0;
    bit         m_rr   = 1'b0;
    bit         m_drop = 1'b0;
    logic [15:0] m_data = '0;
    int         m_ch   = 0;
    int         m_left = 0;
    int         m_ptr  = 0;
    int         drop_seen = 0;

    dmux8way_dispatch #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .mode      (mode),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out5      (out5),
        .out6      (out6),
        .out7      (out7),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop      (drop),
        .rr_ptr    (rr_ptr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] obs,
                               input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check the
    // combinational ready, advance the model on the rising edge and compare
    // all registered outputs shortly afterwards.
    task automatic applyStimulus(input logic rst, input logic iv,
                                 input logic [15:0] d, input logic [2:0] dest,
                                 input logic md, input logic [7:0] ordy);
        bit fire;
        bit expire;
        bit free;
        logic [127:0] exp_bus;
        logic [7:0]   exp_valid;

        @(negedge clk);
        reset     = rst;
        in_valid  = iv;
        in_data   = d;
        in_dest   = dest;
        mode      = md;
        out_ready = ordy;
        #1;

        fire   = m_busy && ordy[m_ch];
        expire = m_busy && !fire && (m_left == 1);
        free   = !m_busy || fire || expire;
        checkOutput("in_ready", {127'd0, in_ready}, {127'd0, (!rst && free)});

        @(posedge clk);
        if (rst) begin
            m_busy = 1'b0;
            m_rr   = 1'b0;
            m_drop = 1'b0;
            m_ptr  = 0;
        end else begin
            m_drop = expire;
            if ((fire || expire) && m_rr) m_ptr = (m_ptr + 1) % 8;
            if (fire || expire) m_busy = 1'b0;
            else if (m_busy) m_left = m_left - 1;
            if (free && iv) begin
                m_busy = 1'b1;
                m_data = d;
                m_ch   = md ? m_ptr : int'(dest);
                m_rr   = md;
                m_left = TIMEOUT;
            end
        end
        #1;

        exp_bus   = '0;
        exp_valid = '0;
        if (m_busy) begin
            exp_bus[m_ch*16 +: 16] = m_data;
            exp_valid = 8'h01 << m_ch;
        end
        if (drop === 1'b1) drop_seen++;
        checkOutput("out_valid", {120'd0, out_valid}, {120'd0, exp_valid});
        checkOutput("out_bus", {out7, out6, out5, out4, out3, out2, out1, out0}, exp_bus);
        checkOutput("drop", {127'd0, drop}, {127'd0, m_drop});
        checkOutput("rr_ptr", {125'd0, rr_ptr}, 128'(m_ptr));
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dest   = '0;
        mode      = 1'b0;
        out_ready = '0;

        // Reset with garbage on the inputs must not accept anything.
        applyStimulus(1'b1, 1'b1, 16'h1234, 3'd4, 1'b0, 8'hFF);
        applyStimulus(1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 8'h00);

        // Addressed word to channel 5, then let it drain.
        applyStimulus(1'b0, 1'b1, 16'hA5A5, 3'd5, 1'b0, 8'hFF);
        checkOutput("addr_valid5", {120'd0, out_valid}, {120'd0, 8'b0010_0000});
        checkOutput("addr_out5", {112'd0, out5}, {112'd0, 16'hA5A5});
        applyStimulus(1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'hFF);
        checkOutput("addr_ptr", {125'd0, rr_ptr}, 128'd0);

        // Round-robin burst of ten words, one per cycle, pointer wraps.
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b0, 1'b1, 16'(i), 3'd7, 1'b1, 8'hFF);
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 3'd0, 1'b1, 8'hFF);
        checkOutput("rr_wrap_ptr", {125'd0, rr_ptr}, 128'd2);

        // Backpressure on channel 2 for four cycles, other channels ready.
        drop_seen = 0;
        applyStimulus(1'b0, 1'b1, 16'h2222, 3'd2, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 16'h3333, 3'd0, 1'b0, 8'hFB);
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'hFF);
        checkOutput("bp_no_drop", 128'(drop_seen), 128'd0);

        // Dead consumer on channel 3: exactly one drop after 15 HOLD cycles.
        drop_seen = 0;
        applyStimulus(1'b0, 1'b1, 16'h3C3C, 3'd3, 1'b0, 8'h00);
        for (int i = 0; i < TIMEOUT; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'h00);
        end
        checkOutput("to_drop_now", {127'd0, drop}, {127'd0, 1'b1});
        checkOutput("to_valid_clr", {120'd0, out_valid}, 128'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 16'h4444, 3'd4, 1'b0, 8'hFF);
        checkOutput("to_next_valid", {120'd0, out_valid}, {120'd0, 8'b0001_0000});
        checkOutput("to_drop_once", 128'(drop_seen), 128'd1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'hFF);

        // Reset while holding 0xBEEF on channel 6 with a non-zero pointer.
        applyStimulus(1'b0, 1'b1, 16'h5555, 3'd0, 1'b1, 8'hFF);
        applyStimulus(1'b0, 1'b1, 16'hBEEF, 3'd6, 1'b0, 8'hFF);
        applyStimulus(1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 16'h6666, 3'd1, 1'b0, 8'hFF);
        checkOutput("rst_out6", {112'd0, out6}, 128'd0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 8'h00);

        // Channel 1 held while every other channel is ready.
        applyStimulus(1'b0, 1'b1, 16'h1111, 3'd1, 1'b0, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'b1111_1101);
        end
        checkOutput("foreign_hold", {112'd0, out1}, {112'd0, 16'h1111});
        applyStimulus(1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'hFF);

        // Randomized traffic; every third 40-cycle phase has no ready at all
        // so timeouts and drops occur alongside normal transfers.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] ordy;
            ordy = 8'($urandom);
            if (((i / 40) % 3) == 2) ordy = 8'h00;
            applyStimulus(($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 1) == 1),
                          16'($urandom),
                          3'($urandom),
                          ($urandom_range(0, 1) == 1),
                          ordy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
